// File: rtl/fetch_mem_if.sv
// rtl/fetch_mem_if.sv - instruction-memory read port (req/ack, variable latency)
interface fetch_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/fetch_mem_ctrl.sv
// rtl/fetch_mem_ctrl.sv - fetch-stage instruction-memory sequencer with stall merge and redirect kill
// Optional fetch/wait perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_mem_ctrl #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
`ifdef FETCH_PERF_CNT_EN
   ,
   parameter int                CNT_W     = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] PCF,
   input  logic [ADDR_W-1:0] PCTarget,
   input  logic              PcSrc,
   input  logic              StallF,
   fetch_mem_if.master       mem,
   output logic [DATA_W-1:0] Instr_RD,
   output logic              instr_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic              fetch_stall,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic [CNT_W-1:0]  wait_cnt
`else
   output logic              fetch_stall
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

   state_t            state;
   logic              ack;
   logic [ADDR_W-1:0] pc_next;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

   // An ack outside an active request is a stray and must never be consumed.
   assign ack     = mem.mem_req & mem.mem_ack;
   assign pc_next = word_align(PcSrc ? PCTarget : PCF + ADDR_W'(4));

   always_comb begin
      fetch_stall = 1'b1;
      case (state)
         REQ:     fetch_stall = StallF | ~ack;
         HOLD:    fetch_stall = StallF;
         default: fetch_stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         Instr_RD     <= NOP_INSTR;
         instr_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mem.mem_addr <= word_align(PCF);
               mem.mem_req  <= 1'b1;
               state        <= REQ;
            end
            REQ: begin
               if (ack) begin
                  if (PcSrc) begin
                     Instr_RD     <= NOP_INSTR;
                     instr_valid  <= 1'b0;
                     mem.mem_addr <= pc_next;
                  end else if (StallF) begin
                     Instr_RD     <= mem.mem_rdata;
                     instr_valid  <= 1'b1;
                     mem.mem_req  <= 1'b0;
                     state        <= HOLD;
                  end else begin
                     Instr_RD     <= mem.mem_rdata;
                     instr_valid  <= 1'b1;
                     mem.mem_addr <= pc_next;
                  end
               end else begin
                  Instr_RD    <= NOP_INSTR;
                  instr_valid <= 1'b0;
                  // The read cannot be withdrawn; wait out its ack before retargeting.
                  if (PcSrc) begin
                     state <= KILL;
                  end
               end
            end
            HOLD: begin
               if (PcSrc) begin
                  Instr_RD     <= NOP_INSTR;
                  instr_valid  <= 1'b0;
                  mem.mem_addr <= pc_next;
                  mem.mem_req  <= 1'b1;
                  state        <= REQ;
               end else if (!StallF) begin
                  mem.mem_addr <= pc_next;
                  mem.mem_req  <= 1'b1;
                  state        <= REQ;
               end
            end
            KILL: begin
               if (ack) begin
                  mem.mem_addr <= word_align(PcSrc ? PCTarget : PCF);
                  state        <= REQ;
               end
            end
            default: begin
               mem.mem_req <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (state == REQ && ack && !PcSrc && fetch_cnt != '1) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         end
         if (fetch_stall && !StallF && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
